four_bool_evaluator: RTL and testbench
======================================

FOUR_BOOL_EVALUATOR -- requirements
Module: four_bool_evaluator

Interface
REQ-001 The block SHALL have one parameter, SETTLE_CYCLES, default 4, setting the number of clock cycles each input vector is held before the candidate outputs are sampled; the legal range SHALL be 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: a synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one evaluation run.
REQ-005 The block SHALL have port target, input, 64 bits: expected truth table, with bits [4i+3:4i] giving the expected candidate outputs {output3..output0} for input vector i.
REQ-006 The block SHALL have port dut_in, output, 4 bits: drives the candidate circuit inputs {input3..input0}.
REQ-007 The block SHALL have port dut_out, input, 4 bits: the candidate circuit outputs {output3..output0}.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-010 The block SHALL have port score, output, 7 bits: the count of matching output bits, 0..64.
REQ-011 The block SHALL have port perfect, output, 1 bit: high when score equals 64.
REQ-012 The block SHALL have port mismatch_mask, output, 16 bits: bit i is high if any output bit of vector i mismatched.

Function
REQ-013 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 start SHALL be accepted only in IDLE.
- In all other states start SHALL be ignored, with no queuing.
REQ-015 On an accepted start at cycle T0, the block SHALL perform all of the following:
- latch target internally;
- clear score and mismatch_mask;
- set the vector index to 0;
- enter SETTLE at T0+1 with dut_in=0 and busy=1.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles and then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle, and in that cycle the block SHALL do both of the following:
- compare dut_out against the latched slice for the current vector;
- add the popcount of the bitwise XNOR (0..4) to score, and set mismatch_mask[i] if the popcount is less than 4.
REQ-018 After SAMPLE, if the index is less than 15, the block SHALL increment the index, set dut_in to the new index, and return to SETTLE.
- dut_in SHALL change only on this transition.
REQ-019 After SAMPLE of index 15, the block SHALL go to DONE.
- DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-020 done SHALL be high at cycle T0+1+16*(SETTLE_CYCLES+1) and at no other time in the run.
REQ-021 score, perfect and mismatch_mask SHALL be valid while done=1 and SHALL be held unchanged until the next accepted start.
REQ-022 In IDLE, dut_in SHALL hold the value it had at the end of the previous run (15), or 0 after reset.
REQ-023 Changes on target after start is accepted SHALL NOT affect the current run.
REQ-024 score SHALL NOT wrap; its maximum is 64 by construction.
REQ-025 perfect SHALL be combinationally equal to (score == 64).

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL enter IDLE and set all of the following to 0:
- dut_in, busy, done, score and mismatch_mask;
- the vector index and the settle counter.
REQ-027 reset SHALL take priority over start in the same cycle.
REQ-028 reset during a run SHALL abort the run without a done pulse, and the next start SHALL begin a fresh run.

Verification
REQ-029 Loopback (dut_out=dut_in), target=64'hFEDCBA9876543210, start at T0 -> done at T0+81, score=64, perfect=1, mismatch_mask=16'h0000.
REQ-030 Loopback, target=64'h0 -> score=32, perfect=0, mismatch_mask=16'hFFFE.
REQ-031 dut_out tied to 4'hF, target=64'hFFFF_FFFF_FFFF_FFFF -> score=64 and perfect=1; the same stimulus with target=64'h0 -> score=0 and mismatch_mask=16'hFFFF.
REQ-032 Loopback identity run with start re-pulsed at T0+10 and at the DONE cycle -> exactly one done, at T0+81; the block is idle afterward.
REQ-033 Reset asserted at T0+40 -> next cycle busy=0, dut_in=0, score=0, and no done; a new start then yields done 81 cycles later with score=64.
REQ-034 SETTLE_CYCLES=1, loopback identity -> done at T0+33, score=64; each dut_in value is held exactly 2 cycles.

Source files
------------

// File: rtl/four_bool_evaluator.sv
// Exhaustive evaluator for a 4-input / 4-output candidate circuit. Drives every input
// vector in turn, lets the candidate settle, then scores its outputs bit by bit against
// a 64-bit expected truth table latched at start.
module four_bool_evaluator #(
  parameter int unsigned SETTLE_CYCLES = 4  // legal range 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] target,
  output logic [3:0]  dut_in,
  input  logic [3:0]  dut_out,
  output logic        busy,
  output logic        done,
  output logic [6:0]  score,
  output logic        perfect,
  output logic [15:0] mismatch_mask
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [63:0] target_q, target_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  score_q, score_d;
  logic [15:0] mask_q, mask_d;

  logic [3:0]  expected;
  logic [3:0]  agree;
  logic [2:0]  hits;

  // Per-vector comparison: number of candidate output bits that match the latched slice.
  always_comb begin
    expected = target_q[{idx_q, 2'b00} +: 4];
    agree    = ~(dut_out ^ expected);
    hits     = 3'(agree[0]) + 3'(agree[1]) + 3'(agree[2]) + 3'(agree[3]);
  end

  // Next-state logic and decoded status outputs.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    score_d  = score_q;
    mask_d   = mask_q;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          target_d = target;
          score_d  = '0;
          mask_d   = '0;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        busy = 1'b1;
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSample: begin
        busy    = 1'b1;
        // Cannot wrap: at most 16 samples of 4 matching bits each.
        score_d = score_q + 7'(hits);
        if (hits != 3'd4) begin
          mask_d[idx_q] = 1'b1;
        end
        if (idx_q == 4'd15) begin
          state_d = StDone;
        end else begin
          // Only place the candidate inputs ever change during a run.
          idx_d   = idx_q + 4'd1;
          state_d = StSettle;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; results persist across IDLE until the next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      target_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      score_q  <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      score_q  <= score_d;
      mask_q   <= mask_d;
    end
  end

  assign dut_in        = idx_q;
  assign score         = score_q;
  assign mismatch_mask = mask_q;
  assign perfect       = (score_q == 7'd64);

endmodule

// File: tb/tb_four_bool_evaluator.sv
// Self-checking bench: a table-driven candidate circuit is scored against a truth-table model.
module tb_four_bool_evaluator;

  localparam int Settle = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] target = '0;
  logic [3:0]  dut_in, dut_out;
  logic        busy, done, perfect;
  logic [6:0]  score;
  logic [15:0] mismatch_mask;

  logic        start1 = 1'b0;
  logic [63:0] target1 = '0;
  logic [3:0]  dut1_in, dut1_out;
  logic        busy1, done1, perfect1;
  logic [6:0]  score1;
  logic [15:0] mask1;

  // Candidate circuit: output for input vector i is resp[i].
  logic [3:0]  resp [16];

  int checks = 0;
  int failures = 0;

  assign dut_out  = resp[dut_in];
  assign dut1_out = resp[dut1_in];

  always #5 clk = ~clk;

  four_bool_evaluator #(.SETTLE_CYCLES(Settle)) dut (
    .clk(clk), .reset(reset), .start(start), .target(target), .dut_in(dut_in),
    .dut_out(dut_out), .busy(busy), .done(done), .score(score), .perfect(perfect),
    .mismatch_mask(mismatch_mask)
  );

  four_bool_evaluator #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .target(target1), .dut_in(dut1_in),
    .dut_out(dut1_out), .busy(busy1), .done(done1), .score(score1), .perfect(perfect1),
    .mismatch_mask(mask1)
  );

  function automatic int model_score(input logic [63:0] t);
    int s = 0;
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 4; b++)
        if (resp[i][b] == t[4*i+b]) s++;
    return s;
  endfunction

  function automatic logic [15:0] model_mask(input logic [63:0] t);
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) m[i] = (resp[i] != t[4*i +: 4]);
    return m;
  endfunction

  task automatic set_identity();
    for (int i = 0; i < 16; i++) resp[i] = 4'(i);
  endtask

  task automatic set_const(input logic [3:0] v);
    for (int i = 0; i < 16; i++) resp[i] = v;
  endtask

  // Drives one run on the SETTLE_CYCLES=4 instance and observes it for 100 cycles.
  // k counts cycles after the accepting edge T0; target is scrambled once accepted.
  task automatic do_run(input logic [63:0] tgt, input int repulse, input int rst_at,
                        output int done_cyc, output int ndone, output logic [6:0] sc,
                        output logic [15:0] mk, output logic pf, output int hold_errs,
                        output logic rst_busy, output logic [3:0] rst_in,
                        output logic [6:0] rst_score);
    done_cyc = -1; ndone = 0; sc = '0; mk = '0; pf = 1'b0; hold_errs = 0;
    rst_busy = 1'b1; rst_in = 4'hF; rst_score = 7'h7F;
    @(negedge clk);
    start = 1'b1;
    target = tgt;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) target = {$urandom, $urandom};
      if (done) begin
        ndone++; done_cyc = k; sc = score; mk = mismatch_mask; pf = perfect;
      end
      if (rst_at == 0 && k <= 80 && dut_in !== 4'((k - 1) / (Settle + 1))) hold_errs++;
      if (rst_at != 0 && k == rst_at + 1) begin
        rst_busy = busy; rst_in = dut_in; rst_score = score; reset = 1'b0;
      end
      if (rst_at != 0 && k == rst_at) reset = 1'b1;
      if (repulse != 0 && (k == repulse || done)) start = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (score !== 7'd0) begin failures++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (mismatch_mask !== 16'h0) begin failures++; $display("FAIL reset_mask: got %h want 0000", mismatch_mask); end
    checks++; if (dut_in !== 4'h0) begin failures++; $display("FAIL reset_dut_in: got %h want 0", dut_in); end
    checks++; if (perfect !== 1'b0) begin failures++; $display("FAIL reset_perfect: got %b want 0", perfect); end
    // Start while reset is high must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_priority: busy got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_queue: busy got %b want 0", busy); end
  endtask

  task automatic test_identity();
    int dc, nd, he; logic [6:0] sc, rs; logic [15:0] mk; logic pf, rb; logic [3:0] ri;
    set_identity();
    do_run(64'hFEDCBA9876543210, 0, 0, dc, nd, sc, mk, pf, he, rb, ri, rs);
    checks++; if (dc != 81) begin failures++; $display("FAIL id_done_cycle: got %0d want 81", dc); end
    checks++; if (nd != 1) begin failures++; $display("FAIL id_done_count: got %0d want 1", nd); end
    checks++; if (sc !== 7'd64) begin failures++; $display("FAIL id_score: got %0d want 64", sc); end
    checks++; if (pf !== 1'b1) begin failures++; $display("FAIL id_perfect: got %b want 1", pf); end
    checks++; if (mk !== 16'h0) begin failures++; $display("FAIL id_mask: got %h want 0000", mk); end
    checks++; if (he != 0) begin failures++; $display("FAIL id_dut_in_hold: got %0d bad cycles want 0", he); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL id_idle_busy: got %b want 0", busy); end
    checks++; if (dut_in !== 4'hF) begin failures++; $display("FAIL id_idle_dut_in: got %h want f", dut_in); end
    checks++; if (score !== 7'd64) begin failures++; $display("FAIL id_score_held: got %0d want 64", score); end
  endtask

  task automatic test_zero_target();
    int dc, nd, he; logic [6:0] sc, rs; logic [15:0] mk; logic pf, rb; logic [3:0] ri;
    set_identity();
    do_run(64'h0, 0, 0, dc, nd, sc, mk, pf, he, rb, ri, rs);
    checks++; if (sc !== 7'd32) begin failures++; $display("FAIL zero_score: got %0d want 32", sc); end
    checks++; if (pf !== 1'b0) begin failures++; $display("FAIL zero_perfect: got %b want 0", pf); end
    checks++; if (mk !== 16'hFFFE) begin failures++; $display("FAIL zero_mask: got %h want fffe", mk); end
  endtask

  task automatic test_tied_high();
    int dc, nd, he; logic [6:0] sc, rs; logic [15:0] mk; logic pf, rb; logic [3:0] ri;
    set_const(4'hF);
    do_run(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, dc, nd, sc, mk, pf, he, rb, ri, rs);
    checks++; if (sc !== 7'd64) begin failures++; $display("FAIL tied_ones_score: got %0d want 64", sc); end
    checks++; if (pf !== 1'b1) begin failures++; $display("FAIL tied_ones_perfect: got %b want 1", pf); end
    do_run(64'h0, 0, 0, dc, nd, sc, mk, pf, he, rb, ri, rs);
    checks++; if (sc !== 7'd0) begin failures++; $display("FAIL tied_zero_score: got %0d want 0", sc); end
    checks++; if (mk !== 16'hFFFF) begin failures++; $display("FAIL tied_zero_mask: got %h want ffff", mk); end
  endtask

  task automatic test_repulse();
    int dc, nd, he; logic [6:0] sc, rs; logic [15:0] mk; logic pf, rb; logic [3:0] ri;
    set_identity();
    do_run(64'hFEDCBA9876543210, 10, 0, dc, nd, sc, mk, pf, he, rb, ri, rs);
    checks++; if (nd != 1) begin failures++; $display("FAIL repulse_done_count: got %0d want 1", nd); end
    checks++; if (dc != 81) begin failures++; $display("FAIL repulse_done_cycle: got %0d want 81", dc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL repulse_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_midrun();
    int dc, nd, he; logic [6:0] sc, rs; logic [15:0] mk; logic pf, rb; logic [3:0] ri;
    set_identity();
    do_run(64'hFEDCBA9876543210, 0, 40, dc, nd, sc, mk, pf, he, rb, ri, rs);
    checks++; if (rb !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", rb); end
    checks++; if (ri !== 4'h0) begin failures++; $display("FAIL abort_dut_in: got %h want 0", ri); end
    checks++; if (rs !== 7'd0) begin failures++; $display("FAIL abort_score: got %0d want 0", rs); end
    checks++; if (nd != 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses want 0", nd); end
    do_run(64'hFEDCBA9876543210, 0, 0, dc, nd, sc, mk, pf, he, rb, ri, rs);
    checks++; if (dc != 81) begin failures++; $display("FAIL abort_rerun_cycle: got %0d want 81", dc); end
    checks++; if (sc !== 7'd64) begin failures++; $display("FAIL abort_rerun_score: got %0d want 64", sc); end
  endtask

  task automatic test_random();
    int dc, nd, he, exp_sc; logic [6:0] sc, rs; logic [15:0] mk, exp_mk; logic pf, rb;
    logic [3:0] ri; logic [63:0] t;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 16; i++) resp[i] = 4'($urandom);
      t = {$urandom, $urandom};
      // Bias some runs toward near-perfect tables so high scores are exercised.
      if (n % 4 == 0)
        for (int i = 0; i < 16; i++) t[4*i +: 4] = resp[i];
      if (n % 4 == 1)
        for (int i = 0; i < 16; i++) t[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : resp[i];
      exp_sc = model_score(t);
      exp_mk = model_mask(t);
      do_run(t, 0, 0, dc, nd, sc, mk, pf, he, rb, ri, rs);
      checks++; if (dc != 81 || nd != 1) begin failures++; $display("FAIL rand_done[%0d]: got cycle %0d count %0d want 81/1", n, dc, nd); end
      checks++; if (int'(sc) != exp_sc) begin failures++; $display("FAIL rand_score[%0d]: got %0d want %0d", n, sc, exp_sc); end
      checks++; if (mk !== exp_mk) begin failures++; $display("FAIL rand_mask[%0d]: got %h want %h", n, mk, exp_mk); end
      checks++; if (pf !== (exp_sc == 64)) begin failures++; $display("FAIL rand_perfect[%0d]: got %b want %b", n, pf, exp_sc == 64); end
    end
  endtask

  task automatic test_settle1();
    int dc = -1, nd = 0, he = 0; logic [6:0] sc = '0;
    set_identity();
    @(negedge clk);
    start1 = 1'b1;
    target1 = 64'hFEDCBA9876543210;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (k == 1) target1 = {$urandom, $urandom};
      if (done1) begin nd++; dc = k; sc = score1; end
      if (k <= 32 && dut1_in !== 4'((k - 1) / 2)) he++;
    end
    checks++; if (dc != 33) begin failures++; $display("FAIL s1_done_cycle: got %0d want 33", dc); end
    checks++; if (nd != 1) begin failures++; $display("FAIL s1_done_count: got %0d want 1", nd); end
    checks++; if (sc !== 7'd64) begin failures++; $display("FAIL s1_score: got %0d want 64", sc); end
    checks++; if (he != 0) begin failures++; $display("FAIL s1_dut_in_hold: got %0d bad cycles want 0", he); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) resp[i] = '0;
    test_reset();
    test_identity();
    test_zero_target();
    test_tied_high();
    test_repulse();
    test_reset_midrun();
    test_random();
    test_settle1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
